// File: rtl/spm_pkg.sv
// Shared definitions for the SPM operand serializer: default widths, FSM state type
// and the index of the last bit in a 2N-bit stream.
package spm_pkg;

    localparam int N_DEF    = 8;
    localparam int CW_DEF   = 4;
    localparam int LAST_IDX = 2 * N_DEF - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spm_bit_counter.sv
// Mod-(LAST+1) up-counter for the serial bit index; clear wins over count-enable,
// and terminal flags the final index of a stream.
module spm_bit_counter #(
    parameter int CW   = 4,
    parameter int LAST = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          terminal
);

    assign terminal = (count == CW'(LAST));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/spm_operand_serializer.sv
// Operand front-end for the signed serial-parallel multiplier: streams the multiplier
// LSB-first sign-extended to 2N bits. Optional stall input under `SPM_SER_STALL_EN.
module spm_operand_serializer
    import spm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
`ifdef SPM_SER_STALL_EN
    input  logic          stall,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_mplier,
    input  logic [N-1:0]  in_mcand,
    output logic [N-1:0]  mcand_q,
    output logic          ser_bit,
    output logic          ser_valid,
    output logic          ser_first,
    output logic          ser_last,
    output logic [CW-1:0] bit_idx,
    output logic          busy
);

    localparam int LAST = 2 * N - 1;

    state_t         state, state_nx;
    logic [N-1:0]   shreg;
    logic           stall_w;
    logic           shifting;
    logic           terminal;
    logic           accept;

`ifdef SPM_SER_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // A stalled SHIFT cycle is invisible downstream: nothing advances or is flagged.
    assign shifting  = (state == SHIFT) && !stall_w;
    assign ser_valid = shifting;
    assign ser_first = shifting && (bit_idx == '0);
    assign ser_last  = shifting && terminal;
    assign ser_bit   = (state == SHIFT) ? shreg[0] : 1'b0;
    assign busy      = (state == SHIFT);
    assign in_ready  = (state == IDLE) || ser_last;
    assign accept    = in_valid && in_ready;

    spm_bit_counter #(
        .CW   (CW),
        .LAST (LAST)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (shifting),
        .clear    (accept),
        .count    (bit_idx),
        .terminal (terminal)
    );

    always_comb begin
        // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (ser_last && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            mcand_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                shreg   <= in_mplier;
                mcand_q <= in_mcand;
            end else if (shifting) begin
                shreg <= {shreg[N-1], shreg[N-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_spm_operand_serializer.sv
// Self-checking bench for spm_operand_serializer: directed and random operand streams
// compared against a sign-extension reference model.
module tb_spm_operand_serializer;
    import spm_pkg::*;

    localparam int N  = N_DEF;
    localparam int CW = CW_DEF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_mplier = '0;
    logic [N-1:0]  in_mcand = '0;
    logic [N-1:0]  mcand_q;
    logic          ser_bit;
    logic          ser_valid;
    logic          ser_first;
    logic          ser_last;
    logic [CW-1:0] bit_idx;
    logic          busy;
`ifdef SPM_SER_STALL_EN
    logic          stall = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spm_operand_serializer dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SPM_SER_STALL_EN
        .stall     (stall),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mplier (in_mplier),
        .in_mcand  (in_mcand),
        .mcand_q   (mcand_q),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .bit_idx   (bit_idx),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit k of the multiplier viewed as a signed integer (sign extension for k >= N).
    function automatic logic ref_bit(input logic [N-1:0] m, input int k);
        int v;
        v = int'($signed(m));
        return v[k];
    endfunction

    task automatic check_idle(input string tag, input logic [N-1:0] exp_mcand);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        check({tag, ".busy"},  32'(busy), 32'd0);
        check({tag, ".valid"}, 32'(ser_valid), 32'd0);
        check({tag, ".bit"},   32'(ser_bit), 32'd0);
        check({tag, ".first"}, 32'(ser_first), 32'd0);
        check({tag, ".last"},  32'(ser_last), 32'd0);
        check({tag, ".idx"},   32'(bit_idx), 32'd0);
        check({tag, ".mcand"}, 32'(mcand_q), 32'(exp_mcand));
    endtask

    // Present an operand pair while the DUT is ready; it is accepted on the next edge.
    task automatic offer(input logic [N-1:0] m, input logic [N-1:0] c);
        @(negedge clk);
        check("offer.ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_mplier = m;
        in_mcand  = c;
    endtask

    // Check one full 2N-bit stream that was accepted on the preceding edge. During the
    // stream the inputs carry the next operand (has_next) or nothing; poke_idx>=0 pulses
    // a junk in_valid at that index, which must be ignored.
    task automatic play_stream(input logic [N-1:0] m, input logic [N-1:0] c,
                               input bit has_next, input logic [N-1:0] nm,
                               input logic [N-1:0] nc, input int poke_idx);
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_valid  = has_next;
                in_mplier = has_next ? nm : '0;
                in_mcand  = has_next ? nc : '0;
            end
            if (!has_next) begin
                in_valid = (k == poke_idx);
                if (k == poke_idx) begin
                    in_mplier = ~m;
                    in_mcand  = ~c;
                end
            end
            check($sformatf("s%02h.k%0d.valid", m, k), 32'(ser_valid), 32'd1);
            check($sformatf("s%02h.k%0d.bit", m, k),   32'(ser_bit), 32'(ref_bit(m, k)));
            check($sformatf("s%02h.k%0d.idx", m, k),   32'(bit_idx), 32'(k));
            check($sformatf("s%02h.k%0d.first", m, k), 32'(ser_first), 32'(k == 0));
            check($sformatf("s%02h.k%0d.last", m, k),  32'(ser_last), 32'(k == LAST_IDX));
            check($sformatf("s%02h.k%0d.ready", m, k), 32'(in_ready), 32'(k == LAST_IDX));
            check($sformatf("s%02h.k%0d.busy", m, k),  32'(busy), 32'd1);
            check($sformatf("s%02h.k%0d.mcand", m, k), 32'(mcand_q), 32'(c));
        end
    endtask

    task automatic finish_idle(input logic [N-1:0] c);
        @(negedge clk);
        in_valid = 1'b0;
        check_idle("post", c);
    endtask

    logic [N-1:0] ra_m, ra_c, rb_m, rb_c;
    bit           chain;

    initial begin
        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset", '0);

        // Directed positive, negative and extreme operands, with an ignored pulse at k=3.
        offer(8'h05, 8'h07);
        play_stream(8'h05, 8'h07, 1'b0, '0, '0, 3);
        finish_idle(8'h07);
        offer(8'hFD, 8'h11);
        play_stream(8'hFD, 8'h11, 1'b0, '0, '0, -1);
        finish_idle(8'h11);
        offer(8'h80, 8'h7F);
        play_stream(8'h80, 8'h7F, 1'b0, '0, '0, -1);
        finish_idle(8'h7F);

        // Back-to-back: second pair accepted on the first stream's ser_last cycle.
        offer(8'h05, 8'h07);
        play_stream(8'h05, 8'h07, 1'b1, 8'hFD, 8'hC3, -1);
        play_stream(8'hFD, 8'hC3, 1'b0, '0, '0, -1);
        finish_idle(8'hC3);

        // Mid-stream reset at bit 5 aborts the stream and clears the operand.
        offer(8'h5A, 8'h3C);
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check("abort.idx", 32'(bit_idx), 32'd5);
        reset = 1'b0;
        @(negedge clk);
        check_idle("abort", '0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort.rel", '0);

        // Random operands with random chaining.
        ra_m = N'($urandom);
        ra_c = N'($urandom);
        offer(ra_m, ra_c);
        for (int i = 0; i < 24; i++) begin
            chain = (i != 23) && ($urandom_range(0, 1) == 1);
            rb_m  = N'($urandom);
            rb_c  = N'($urandom);
            play_stream(ra_m, ra_c, chain, rb_m, rb_c, chain ? -1 : int'($urandom_range(0, 14)));
            if (chain) begin
                ra_m = rb_m;
                ra_c = rb_c;
            end else begin
                finish_idle(ra_c);
                ra_m = N'($urandom);
                ra_c = N'($urandom);
                if (i != 23) offer(ra_m, ra_c);
            end
        end

`ifdef SPM_SER_STALL_EN
        // Stall for three cycles at bit 4: the stream stretches to 19 cycles.
        offer(8'hB6, 8'h29);
        for (int cyc = 1; cyc <= 2 * N + 3; cyc++) begin
            int  k;
            bit  st;
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            if (cyc == 5) stall = 1'b1;
            if (cyc == 8) stall = 1'b0;
            st = (cyc >= 5) && (cyc < 8);
            k  = (cyc < 5) ? cyc - 1 : (st ? 4 : cyc - 4);
            check($sformatf("stall.c%0d.valid", cyc), 32'(ser_valid), 32'(!st));
            check($sformatf("stall.c%0d.idx", cyc),   32'(bit_idx), 32'(k));
            check($sformatf("stall.c%0d.bit", cyc),   32'(ser_bit), 32'(ref_bit(8'hB6, k)));
            check($sformatf("stall.c%0d.last", cyc),  32'(ser_last), 32'(!st && k == LAST_IDX));
            check($sformatf("stall.c%0d.first", cyc), 32'(ser_first), 32'(!st && k == 0));
            check($sformatf("stall.c%0d.ready", cyc), 32'(in_ready), 32'(!st && k == LAST_IDX));
        end
        finish_idle(8'h29);
        stall = 1'b1;
        offer(8'h01, 8'h02);
        stall = 1'b0;
        play_stream(8'h01, 8'h02, 1'b0, '0, '0, -1);
        finish_idle(8'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spm_operand_serializer.md
Name: spm_operand_serializer

Overview:
Operand front-end for the signed 8x8 serial-parallel multiplier (SPM). Accepts a signed multiplier/multiplicand pair on a valid/ready handshake and holds the multiplicand as a stable parallel word. Streams the multiplier LSB-first, sign-extended to 2N bits, one bit per clock. Framing markers let the downstream SPM array and product collector align with the stream.

Parameters:
N, 8, operand width in bits (signed, two's complement)
CW, 4, bit-index counter width; must satisfy 2^CW >= 2N

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair this cycle
in_mplier  input  N  signed multiplier, serialized
in_mcand  input  N  signed multiplicand, held in parallel
mcand_q  output  N  registered multiplicand; stable for the whole stream
ser_bit  output  1  current serial multiplier bit
ser_valid  output  1  ser_bit is meaningful this cycle
ser_first  output  1  high on bit index 0 of a stream
ser_last  output  1  high on bit index 2N-1 of a stream
bit_idx  output  CW  index of the current serial bit (0..2N-1)
busy  output  1  high while streaming (state SHIFT)

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; shift reg, mcand_q, bit_idx=0; ser_valid, ser_first, ser_last, busy=0; in_ready=1 from the first cycle after reset. Asserting reset mid-stream aborts the stream, discards the operand, and drops ser_valid on that edge.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on ser_last with a simultaneous accept (back-to-back).
  - SHIFT -> IDLE on ser_last without accept.
- in_ready = (state==IDLE) || (state==SHIFT && ser_last). It is combinational from state and bit_idx only; there is no dependence on in_valid.
- Accept = in_valid && in_ready at a rising edge. On accept:
  - shift reg <= in_mplier; mcand_q <= in_mcand; bit_idx <= 0; state <= SHIFT.
  - Latency: the first ser_bit appears in the cycle after the accept edge.
- In SHIFT:
  - ser_bit = shift reg[0]; ser_valid = 1.
  - Each edge: arithmetic shift right (MSB replicated), bit_idx <= bit_idx+1.
  - Bits N..2N-1 therefore equal the sign bit.
- ser_first = SHIFT && bit_idx==0; ser_last = SHIFT && bit_idx==2N-1.
- Wrap-around: after bit_idx 2N-1, bit_idx returns to 0. It returns to 0 with the new operand if an accept coincides, else it holds 0 in IDLE.
- Back-to-back streams have zero bubble: the last bit of operand A is followed directly by the first bit of operand B.
- mcand_q changes only on accept. It is never modified during a stream, including at ser_last when no accept occurs.
- In IDLE: ser_valid=0; ser_bit=0; ser_first=ser_last=0; busy=0.
- in_valid while busy and not on ser_last is ignored (no accept). The upstream holds its data.

Optional Feature:
SPM_SER_STALL_EN
- Defined: adds input port stall (1 bit).
  - While stall==1 in SHIFT: shift reg, bit_idx and state freeze; ser_valid=0; ser_first/ser_last=0; in_ready=0.
  - Stall in IDLE has no effect.
  - Reset overrides stall.
- Undefined: no stall port; the stream always runs 2N contiguous cycles.

Decomposition:
- Shared package spm_pkg:
  - N and CW defaults.
  - State typedef (IDLE, SHIFT).
  - LAST_IDX = 2N-1 constant.
- One natural sub-module: spm_bit_counter, a mod-2N up-counter with enable, synchronous clear-on-load and sync active-low reset; provides bit_idx and the terminal flag.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, then release -> in_ready=1, busy=0, ser_valid=0, mcand_q=0, bit_idx=0.
- Positive operand: accept mplier=8'h05, mcand=8'h07 -> over 16 cycles ser_bit = 1,0,1,0,0,0,0,0 then eight 0s; ser_first on cycle 1, ser_last on cycle 16; mcand_q=8'h07 throughout; then IDLE.
- Negative and extreme operands: mplier=8'hFD (-3) -> 1,0,1,1,1,1,1,1 then eight 1s; mplier=8'h80 (-128) -> seven 0s, then 1, then eight 1s.
- Back-to-back: in_valid held with 8'h05 then 8'hFD -> second accept on the ser_last cycle of the first stream; 32 contiguous ser_valid cycles; ser_first at bit 17; mcand_q updates exactly at the boundary.
- Mid-stream reset and ignored input: reset=0 at bit_idx=5 -> next cycle ser_valid=0, state IDLE. in_valid pulsed at bit_idx=3 -> no accept, stream unchanged.
- With SPM_SER_STALL_EN: stall=1 for 3 cycles at bit_idx=4 -> ser_valid=0 for 3 cycles; on release, resumes at bit_idx=4 with the same bit; total 19 cycles from accept to ser_last.
